// File: rtl/mem_stage_dmem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_dmem_ctrl_pkg
// Shared definitions for the MIPS memory stage: datapath widths used across
// the pipeline and the 2-bit encoding of the data-memory access FSM. The
// encoding is exported so the state can be observed on the debug port.
// No ports (package).
// ---------------------------------------------------------------------------
package mem_stage_dmem_ctrl_pkg;

    localparam int WORD_LEN        = 32;
    localparam int REG_32_ADDR_LEN = 5;

    // Access FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // An instruction needs the data memory if it is a load or a store.
    function automatic logic is_mem_op(input logic rd_en, input logic wr_en);
        return rd_en | wr_en;
    endfunction

endpackage

// File: rtl/mem_stage_dmem_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_stage_dmem_ctrl_if
// Request/grant/response channel between the memory-stage controller and the
// data memory.
//   master (controller): drives o_dmem_req/we/addr/wdata,
//                        receives i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata.
//   slave  (memory)    : the mirror image.
// Handshake: a request is presented with o_dmem_req=1 and its address, write
// data and write enable held stable until the cycle in which i_dmem_gnt=1;
// that cycle completes the request. For a load, the data arrives in the cycle
// where i_dmem_rvalid=1, which may be the grant cycle itself or any later one.
// gnt/rvalid outside those windows carry no meaning and are ignored.
// ---------------------------------------------------------------------------
interface mem_stage_dmem_ctrl_if;
    import mem_stage_dmem_ctrl_pkg::*;

    logic                o_dmem_req;
    logic                o_dmem_we;
    logic [WORD_LEN-1:0] o_dmem_addr;
    logic [WORD_LEN-1:0] o_dmem_wdata;
    logic                i_dmem_gnt;
    logic                i_dmem_rvalid;
    logic [WORD_LEN-1:0] i_dmem_rdata;

    modport master (
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata,
        input  i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
    );

    modport slave (
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata,
        output i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
    );

endinterface

// File: rtl/mem_stage_dmem_ctrl_wdt.sv
// ---------------------------------------------------------------------------
// dmem_timeout_wdt
// Watchdog for an outstanding data-memory access. Only built when the
// DMEM_TIMEOUT_EN macro is defined.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : access is being launched (IDLE -> REQ edge); clears count
//   active_i      : FSM is in REQ or RESP; count advances
//   abort_o       : combinational, high in the last allowed wait cycle
//   err_o         : registered copy of abort_o, i.e. high in the DONE cycle
// ---------------------------------------------------------------------------
`ifdef DMEM_TIMEOUT_EN
module dmem_timeout_wdt #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic active_i,
    output logic abort_o,
    output logic err_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (active_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    assign abort_o = active_i && (cnt_q == LIMIT);
    assign err_d   = abort_o;
    assign err_o   = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule
`endif

// File: rtl/mem_stage_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_dmem_ctrl
// MIPS memory-stage data-memory access controller. Sits between EX/MEM and
// MEM/WB: launches loads/stores on the data-memory channel, stalls the front
// of the pipeline while an access is outstanding and feeds MEM/WB, inserting
// a bubble while stalled.
// Optional feature: DMEM_TIMEOUT_EN adds a watchdog that aborts an access
// after TIMEOUT_CYCLES wait cycles and pulses o_bus_err.
// Ports:
//   i_sys_clk, i_sys_rst_n         : clock, asynchronous active-low reset
//   i_writeback_en_in, i_MEM_Rd_en, i_MEM_Wr_en, i_dest_in,
//   i_ALU_result_in, i_st_val_in   : EX/MEM contents
//   o_stall                        : freeze PC, IF/ID, ID/EX, EX/MEM
//   o_writebck_en_out, o_MEM_Rd_en, o_dest_out, o_ALU_result_out,
//   o_memread_out                  : MEM/WB inputs
//   o_dbg_state                    : current FSM state (debug)
//   dmem                           : data-memory channel (master side)
//   o_bus_err                      : timeout pulse (DMEM_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module mem_stage_dmem_ctrl
    import mem_stage_dmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       i_sys_clk,
    input  logic                       i_sys_rst_n,
    input  logic                       i_writeback_en_in,
    input  logic                       i_MEM_Rd_en,
    input  logic                       i_MEM_Wr_en,
    input  logic [REG_32_ADDR_LEN-1:0] i_dest_in,
    input  logic [WORD_LEN-1:0]        i_ALU_result_in,
    input  logic [WORD_LEN-1:0]        i_st_val_in,
    output logic                       o_stall,
    output logic                       o_writebck_en_out,
    output logic                       o_MEM_Rd_en,
    output logic [REG_32_ADDR_LEN-1:0] o_dest_out,
    output logic [WORD_LEN-1:0]        o_ALU_result_out,
    output logic [WORD_LEN-1:0]        o_memread_out,
    output logic [1:0]                 o_dbg_state,
    mem_stage_dmem_ctrl_if.master      dmem
`ifdef DMEM_TIMEOUT_EN
    ,
    output logic                       o_bus_err
`endif
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    logic [1:0]          state_q, state_d;
    logic [WORD_LEN-1:0] addr_q, addr_d;
    logic [WORD_LEN-1:0] wdata_q, wdata_d;
    logic [WORD_LEN-1:0] rdata_q, rdata_d;
    logic                we_q, we_d;

    logic mem_op;
    logic start;
    logic waiting;
    logic wdt_abort;
    logic wdt_err;

    assign mem_op  = is_mem_op(i_MEM_Rd_en, i_MEM_Wr_en);
    assign start   = (state_q == ST_IDLE) && mem_op;
    assign waiting = (state_q == ST_REQ) || (state_q == ST_RESP);

`ifdef DMEM_TIMEOUT_EN
    dmem_timeout_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk_i   (i_sys_clk),
        .rst_ni  (i_sys_rst_n),
        .start_i (start),
        .active_i(waiting),
        .abort_o (wdt_abort),
        .err_o   (wdt_err)
    );
    assign o_bus_err = wdt_err;
`else
    assign wdt_abort = 1'b0;
    assign wdt_err   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    state_d = ST_REQ;
                    addr_d  = i_ALU_result_in;
                    wdata_d = i_st_val_in;
                    // Store wins when both enables are set.
                    we_d    = i_MEM_Wr_en;
                end
            end
            ST_REQ: begin
                // A completing access beats the watchdog; otherwise the abort
                // must win over a bare load grant, or the count would run past
                // its limit while waiting in RESP.
                if (dmem.i_dmem_gnt && (we_q || dmem.i_dmem_rvalid)) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rdata_d = dmem.i_dmem_rdata;
                    end
                end else if (wdt_abort) begin
                    state_d = ST_DONE;
                    rdata_d = '0;
                end else if (dmem.i_dmem_gnt) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (dmem.i_dmem_rvalid) begin
                    state_d = ST_DONE;
                    rdata_d = dmem.i_dmem_rdata;
                end else if (wdt_abort) begin
                    state_d = ST_DONE;
                    rdata_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
        end
    end

    assign o_stall = start || waiting;

    // MEM/WB sees a bubble while stalled; an aborted access retires without
    // writeback (wdt_err is only ever high in its DONE cycle).
    assign o_writebck_en_out = i_writeback_en_in & ~o_stall & ~wdt_err;
    assign o_MEM_Rd_en       = i_MEM_Rd_en & ~o_stall;
    assign o_dest_out        = i_dest_in;
    assign o_ALU_result_out  = i_ALU_result_in;
    assign o_memread_out     = rdata_q;
    assign o_dbg_state       = state_q;

    assign dmem.o_dmem_req   = (state_q == ST_REQ);
    assign dmem.o_dmem_we    = (state_q == ST_REQ) && we_q;
    assign dmem.o_dmem_addr  = addr_q;
    assign dmem.o_dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
module tb_mem_stage_dmem_ctrl;
    import mem_stage_dmem_ctrl_pkg::*;

    localparam int TO_CYCLES = 8;
    localparam int EXP_W     = 1 + 1 + REG_32_ADDR_LEN + WORD_LEN + WORD_LEN;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                       wb_in, rd_in, wr_in;
    logic [REG_32_ADDR_LEN-1:0] dest_in;
    logic [WORD_LEN-1:0]        alu_in, st_in;
    logic                       stall, wb_out, rd_out;
    logic [REG_32_ADDR_LEN-1:0] dest_out;
    logic [WORD_LEN-1:0]        alu_out, mrd_out;
    logic [1:0]                 dbg_state;
`ifdef DMEM_TIMEOUT_EN
    logic                       bus_err;
`endif

    mem_stage_dmem_ctrl_if dmem_bus ();

    mem_stage_dmem_ctrl #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .i_sys_clk        (clk),
        .i_sys_rst_n      (rst_n),
        .i_writeback_en_in(wb_in),
        .i_MEM_Rd_en      (rd_in),
        .i_MEM_Wr_en      (wr_in),
        .i_dest_in        (dest_in),
        .i_ALU_result_in  (alu_in),
        .i_st_val_in      (st_in),
        .o_stall          (stall),
        .o_writebck_en_out(wb_out),
        .o_MEM_Rd_en      (rd_out),
        .o_dest_out       (dest_out),
        .o_ALU_result_out (alu_out),
        .o_memread_out    (mrd_out),
        .o_dbg_state      (dbg_state),
        .dmem             (dmem_bus.master)
`ifdef DMEM_TIMEOUT_EN
        ,
        .o_bus_err        (bus_err)
`endif
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0]    exp_q[$];
    logic [WORD_LEN-1:0] model_mrd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_nop();
        wb_in = 1'b0; rd_in = 1'b0; wr_in = 1'b0;
        dest_in = '0; alu_in = '0; st_in = '0;
    endtask

    // Issue one instruction from EX/MEM and act as the data memory.
    // gnt_wait: extra REQ cycles before grant (-1 = never grant).
    // rv_wait : cycles from grant to rvalid for loads (0 = same cycle).
    // Entered and left just after a rising edge.
    task automatic issue(input logic wb, input logic rd, input logic wr,
                         input logic [4:0] dest, input logic [31:0] alu,
                         input logic [31:0] st, input int gnt_wait,
                         input int rv_wait, input logic [31:0] rdata,
                         input logic abort_exp);
        logic            is_mem, is_load, done;
        int              k, stall_n, req_n, exp_stall, exp_req;
        logic [EXP_W-1:0] e;
        logic            e_wb, e_rd;
        logic [4:0]      e_dest;
        logic [31:0]     e_alu, e_mrd;

        is_mem  = rd | wr;
        is_load = rd & ~wr;
        wb_in = wb; rd_in = rd; wr_in = wr;
        dest_in = dest; alu_in = alu; st_in = st;

        if (abort_exp)    model_mrd = '0;
        else if (is_load) model_mrd = rdata;
        exp_q.push_back({wb & ~abort_exp, rd, dest, alu, model_mrd});

        if (!is_mem) begin
            exp_stall = 0; exp_req = 0;
        end else if (abort_exp) begin
            exp_stall = 1 + TO_CYCLES; exp_req = TO_CYCLES;
        end else begin
            exp_stall = 1 + (gnt_wait + 1) + (is_load ? rv_wait : 0);
            exp_req   = gnt_wait + 1;
        end

        k = 0; done = 1'b0; stall_n = 0; req_n = 0;
        while (!done && k < 200) begin
            dmem_bus.i_dmem_gnt    = (gnt_wait >= 0) && (k == 1 + gnt_wait);
            dmem_bus.i_dmem_rvalid = is_load && (gnt_wait >= 0) && (k == 1 + gnt_wait + rv_wait);
            dmem_bus.i_dmem_rdata  = dmem_bus.i_dmem_rvalid ? rdata : $urandom;
            @(negedge clk);
            if (stall) begin
                stall_n++;
                check("bubble_wb", wb_out, 1'b0);
                check("bubble_rd", rd_out, 1'b0);
`ifdef DMEM_TIMEOUT_EN
                check("err_quiet", bus_err, 1'b0);
`endif
                if (dmem_bus.o_dmem_req) begin
                    req_n++;
                    check("req_addr",  dmem_bus.o_dmem_addr,  alu);
                    check("req_wdata", dmem_bus.o_dmem_wdata, st);
                    check("req_we",    dmem_bus.o_dmem_we,    wr);
                end
            end else begin
                done = 1'b1;
                check("sb_nonempty", exp_q.size(), 1);
                e = exp_q.pop_front();
                {e_wb, e_rd, e_dest, e_alu, e_mrd} = e;
                check("ret_wb",   wb_out,   e_wb);
                check("ret_rd",   rd_out,   e_rd);
                check("ret_dest", dest_out, e_dest);
                check("ret_alu",  alu_out,  e_alu);
                check("ret_mrd",  mrd_out,  e_mrd);
`ifdef DMEM_TIMEOUT_EN
                check("ret_err",  bus_err,  abort_exp);
`endif
            end
            @(posedge clk); #1;
            k++;
        end
        dmem_bus.i_dmem_gnt = 1'b0;
        dmem_bus.i_dmem_rvalid = 1'b0;
        check("retired",      done,    1'b1);
        check("stall_cycles", stall_n, exp_stall);
        check("req_cycles",   req_n,   exp_req);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        drive_nop();
        dmem_bus.i_dmem_gnt = 1'b0;
        dmem_bus.i_dmem_rvalid = 1'b0;
        dmem_bus.i_dmem_rdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_req",   dmem_bus.o_dmem_req, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_mrd",   mrd_out, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU instruction, no memory op
        issue(1'b1, 1'b0, 1'b0, 5'd5, 32'h10, 32'h0, 0, 0, 32'h0, 1'b0);
        // Load to give the load-data register a nonzero value
        issue(1'b1, 1'b1, 1'b0, 5'd3, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, 1'b0);

        // Reset in the middle of RESP
        wb_in = 1'b1; rd_in = 1'b1; wr_in = 1'b0; dest_in = 5'd7; alu_in = 32'h300;
        @(posedge clk); #1;
        dmem_bus.i_dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_bus.i_dmem_gnt = 1'b0;
        check("pre_rst_resp", dbg_state, ST_RESP);
        #2;
        rst_n = 1'b0;
        drive_nop();
        #1;
        check("arst_state", dbg_state, ST_IDLE);
        check("arst_req",   dmem_bus.o_dmem_req, 1'b0);
        check("arst_we",    dmem_bus.o_dmem_we, 1'b0);
        check("arst_addr",  dmem_bus.o_dmem_addr, 32'h0);
        check("arst_mrd",   mrd_out, 32'h0);
        check("arst_stall", stall, 1'b0);
        check("arst_wb",    wb_out, 1'b0);
        model_mrd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        dmem_bus.i_dmem_rvalid = 1'b1;
        dmem_bus.i_dmem_rdata  = 32'h12345678;
        @(posedge clk); #1;
        dmem_bus.i_dmem_rvalid = 1'b0;
        @(negedge clk);
        check("stray_rvalid_mrd", mrd_out, 32'h0);
        check("stray_rvalid_st",  dbg_state, ST_IDLE);
        @(posedge clk); #1;

        // Store, grant after 3 wait cycles
        issue(1'b0, 1'b0, 1'b1, 5'd0, 32'h40, 32'hCAFEF00D, 3, 0, 32'h0, 1'b0);
        // Load, grant at first REQ cycle, rvalid 2 cycles later
        issue(1'b1, 1'b1, 1'b0, 5'd8, 32'h80, 32'h0, 0, 2, 32'hA5A5A5A5, 1'b0);
        // Back-to-back loads, gnt and rvalid together
        issue(1'b1, 1'b1, 1'b0, 5'd9, 32'h84, 32'h0, 0, 0, 32'h1, 1'b0);
        issue(1'b1, 1'b1, 1'b0, 5'd10, 32'h88, 32'h0, 1, 0, 32'h55AA00FF, 1'b0);
        // Both enables: the store wins, load data untouched
        issue(1'b0, 1'b1, 1'b1, 5'd11, 32'h90, 32'h13572468, 0, 0, 32'h0, 1'b0);

        // Randomised mix of timings
        for (int i = 0; i < 6; i++) begin
            logic w;
            w = 1'($urandom_range(0, 1));
            issue(~w, ~w, w, 5'($urandom_range(1, 31)), $urandom & 32'hFFFF_FFFC,
                  $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0);
        end
        issue(1'b1, 1'b0, 1'b0, 5'd12, 32'h1234, 32'h0, 0, 0, 32'h0, 1'b0);

`ifdef DMEM_TIMEOUT_EN
        // Grant never comes: abort after TO_CYCLES, then resume
        issue(1'b1, 1'b1, 1'b0, 5'd13, 32'h200, 32'h0, -1, 0, 32'h0, 1'b1);
        issue(1'b0, 1'b0, 1'b1, 5'd0, 32'h204, 32'h600DF00D, 1, 0, 32'h0, 1'b0);
        check("err_after", bus_err, 1'b0);
`endif

        drive_nop();
        @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
